// File: rtl/hex_scroller.sv
// Character FIFO feeding a right-to-left scrolling six-digit 7-segment display.
// Characters enter at HEX0 on each scroll tick; the display drains with blanks when the FIFO runs dry.
module hex_scroller #(
    parameter int TICK_DIV   = 25000000,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          CLOCK,
    input  logic                          RESET,
    input  logic [7:0]                    char_in,
    input  logic                          char_valid,
    output logic                          char_ready,
    output logic [6:0]                    HEX0,
    output logic [6:0]                    HEX1,
    output logic [6:0]                    HEX2,
    output logic [6:0]                    HEX3,
    output logic [6:0]                    HEX4,
    output logic [6:0]                    HEX5,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy,
    output logic [1:0]                    fsm_state
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TICK_DIV);
    localparam logic [6:0] BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCROLL = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    // Push handshake: a character is taken on any rising edge where
    // char_valid && char_ready; char_ready reflects occupancy only.

    state_t          state, state_next;
    logic [2:0]      drain_cnt, drain_next;
    logic [TW-1:0]   tick_cnt;
    logic            tick;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic            push, pop, shift, shift_blank, empty;
    logic [6:0]      new_seg;

    function automatic logic [6:0] seg_decode(input logic [7:0] c);
        case (c)
            8'd65:   seg_decode = 7'b0001000;
            8'd98:   seg_decode = 7'b0000011;
            8'd67:   seg_decode = 7'b1000110;
            8'd100:  seg_decode = 7'b0100001;
            8'd69:   seg_decode = 7'b0000110;
            8'd70:   seg_decode = 7'b0001110;
            8'd103:  seg_decode = 7'b0010000;
            8'd104:  seg_decode = 7'b0001011;
            8'd48:   seg_decode = 7'b1000000;
            8'd49:   seg_decode = 7'b1111001;
            8'd50:   seg_decode = 7'b0100100;
            8'd51:   seg_decode = 7'b0110000;
            8'd52:   seg_decode = 7'b0011001;
            8'd53:   seg_decode = 7'b0010010;
            8'd54:   seg_decode = 7'b0000010;
            8'd55:   seg_decode = 7'b1111000;
            8'd56:   seg_decode = 7'b0000000;
            8'd57:   seg_decode = 7'b0010000;
            default: seg_decode = BLANK;
        endcase
    endfunction

    assign tick       = (tick_cnt == TW'(TICK_DIV - 1));
    assign empty      = (fifo_count == '0);
    assign char_ready = (fifo_count != CW'(FIFO_DEPTH));
    assign push       = char_valid && char_ready;
    assign busy       = (state != IDLE);
    assign fsm_state  = state;
    assign new_seg    = shift_blank ? BLANK : seg_decode(mem[rd_ptr]);

    always_comb begin
        state_next  = state;
        drain_next  = drain_cnt;
        pop         = 1'b0;
        shift       = 1'b0;
        shift_blank = 1'b0;
        if (tick) begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        pop        = 1'b1;
                        shift      = 1'b1;
                        state_next = SCROLL;
                    end
                end
                SCROLL: begin
                    shift = 1'b1;
                    if (!empty) begin
                        pop = 1'b1;
                    end else begin
                        shift_blank = 1'b1;
                        drain_next  = 3'd1;
                        state_next  = DRAIN;
                    end
                end
                DRAIN: begin
                    shift = 1'b1;
                    if (!empty) begin
                        pop        = 1'b1;
                        drain_next = 3'd0;
                        state_next = SCROLL;
                    end else begin
                        shift_blank = 1'b1;
                        // Sixth blank pushes the last character off HEX5.
                        if (drain_cnt == 3'd5) begin
                            drain_next = 3'd0;
                            state_next = IDLE;
                        end else begin
                            drain_next = drain_cnt + 3'd1;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK) begin
        if (push) begin
            mem[wr_ptr] <= char_in;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state      <= IDLE;
            drain_cnt  <= 3'd0;
            tick_cnt   <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
            HEX0 <= BLANK;
            HEX1 <= BLANK;
            HEX2 <= BLANK;
            HEX3 <= BLANK;
            HEX4 <= BLANK;
            HEX5 <= BLANK;
        end else begin
            state     <= state_next;
            drain_cnt <= drain_next;
            tick_cnt  <= tick ? '0 : tick_cnt + TW'(1);
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (shift) begin
                HEX5 <= HEX4;
                HEX4 <= HEX3;
                HEX3 <= HEX2;
                HEX2 <= HEX1;
                HEX1 <= HEX0;
                HEX0 <= new_seg;
            end
        end
    end
endmodule

// File: tb/tb_hex_scroller.sv
// Scoreboard bench for hex_scroller: a queue-and-array model predicts every cycle's
// display, busy, ready and occupancy; a negedge monitor compares the DUT against it.
module tb_hex_scroller;
    localparam int TICK_DIV = 4;
    localparam int DEPTH    = 8;
    localparam int CW       = 4;
    localparam int W        = 48;

    logic       CLOCK = 1'b0;
    logic       RESET;
    logic [7:0] char_in;
    logic       char_valid;
    logic       char_ready;
    logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
    logic [CW-1:0] fifo_count;
    logic       busy;
    logic [1:0] fsm_state;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 CLOCK = ~CLOCK;

    hex_scroller #(.TICK_DIV(TICK_DIV), .FIFO_DEPTH(DEPTH)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .char_in(char_in), .char_valid(char_valid),
        .char_ready(char_ready), .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3),
        .HEX4(HEX4), .HEX5(HEX5), .fifo_count(fifo_count), .busy(busy),
        .fsm_state(fsm_state)
    );

    // ---------------- reference model ----------------
    byte unsigned  m_q[$];
    logic [6:0]    m_disp[6];
    int            m_tick;
    bit            m_active;
    int            m_blanks;
    bit            m_accepted;
    logic [W-1:0]  exp_q[$];

    function automatic logic [6:0] ref_seg(input byte unsigned c);
        string      letters = "AbCdEFgh";
        string      digits  = "0123456789";
        logic [6:0] lseg[8]  = '{7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001,
                                 7'b0000110, 7'b0001110, 7'b0010000, 7'b0001011};
        logic [6:0] dseg[10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000};
        for (int i = 0; i < 8; i++) if (c == letters[i]) return lseg[i];
        for (int i = 0; i < 10; i++) if (c == digits[i]) return dseg[i];
        return 7'h7F;
    endfunction

    always @(posedge CLOCK) begin : model
        bit         is_tick;
        bit         can_take;
        logic [6:0] in_seg;
        m_accepted = 0;
        if (RESET) begin
            m_q.delete();
            for (int i = 0; i < 6; i++) m_disp[i] = 7'h7F;
            m_tick   = 0;
            m_active = 0;
            m_blanks = 0;
        end else begin
            can_take = (m_q.size() < DEPTH);
            is_tick  = (m_tick == TICK_DIV - 1);
            m_tick   = is_tick ? 0 : m_tick + 1;
            if (is_tick && (m_q.size() > 0 || m_active)) begin
                if (m_q.size() > 0) begin
                    in_seg   = ref_seg(m_q.pop_front());
                    m_active = 1;
                    m_blanks = 0;
                end else begin
                    in_seg = 7'h7F;
                    m_blanks++;
                    if (m_blanks == 6) begin
                        m_active = 0;
                        m_blanks = 0;
                    end
                end
                for (int i = 5; i > 0; i--) m_disp[i] = m_disp[i-1];
                m_disp[0] = in_seg;
            end
            if (char_valid && can_take) begin
                m_q.push_back(char_in);
                m_accepted = 1;
            end
        end
        exp_q.push_back({m_disp[5], m_disp[4], m_disp[3], m_disp[2], m_disp[1], m_disp[0],
                         m_active, (m_q.size() < DEPTH), CW'(m_q.size())});
    end

    // ---------------- monitor / scoreboard ----------------
    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge CLOCK) begin : monitor
        logic [W-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("HEX5", 16'(HEX5), 16'(e[47:41]));
            check("HEX4", 16'(HEX4), 16'(e[40:34]));
            check("HEX3", 16'(HEX3), 16'(e[33:27]));
            check("HEX2", 16'(HEX2), 16'(e[26:20]));
            check("HEX1", 16'(HEX1), 16'(e[19:13]));
            check("HEX0", 16'(HEX0), 16'(e[12:6]));
            check("busy", 16'(busy), 16'(e[5]));
            check("char_ready", 16'(char_ready), 16'(e[4]));
            check("fifo_count", 16'(fifo_count), 16'(e[3:0]));
        end
    end

    // ---------------- driver tasks (each returns just after a negedge) ----------------
    task automatic timeout(input string name);
        n_checks++;
        n_fails++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    task automatic send_char(input byte unsigned c);
        int n = 0;
        char_valid = 1'b1;
        char_in    = c;
        do begin
            @(negedge CLOCK);
            n++;
        end while (!m_accepted && n < 200);
        if (!m_accepted) timeout("send_char");
    endtask

    task automatic send_string(input string s);
        for (int i = 0; i < s.len(); i++) send_char(s[i]);
        char_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((m_active || m_q.size() > 0) && n < 500) begin
            @(negedge CLOCK);
            n++;
        end
        if (m_active || m_q.size() > 0) timeout("wait_idle");
    endtask

    task automatic do_reset(input int cycles);
        RESET = 1'b1;
        repeat (cycles) @(negedge CLOCK);
        RESET = 1'b0;
    endtask

    initial begin : stimulus
        string pool = "0123456789AbCdEFgh Z";
        int    n;
        RESET      = 1'b1;
        char_valid = 1'b0;
        char_in    = 8'd0;
        do_reset(2);

        // single character full scroll
        send_string("A");
        wait_idle();
        repeat (3) @(negedge CLOCK);

        // FIFO fill with continuous valid
        send_string("0123456789");
        wait_idle();

        // push exactly on a tick cycle while idle
        n = 0;
        while (m_tick != TICK_DIV - 1 && n < 10) begin
            @(negedge CLOCK);
            n++;
        end
        if (m_tick != TICK_DIV - 1) timeout("tick_align");
        send_string("E");
        wait_idle();

        // resume from drain after two blank shifts
        send_string("Cd");
        n = 0;
        while (!(m_active && m_blanks == 2) && n < 100) begin
            @(negedge CLOCK);
            n++;
        end
        if (!(m_active && m_blanks == 2)) timeout("drain_wait");
        send_string("F");
        repeat (6) @(negedge CLOCK);
        wait_idle();

        // unknown code then reset mid-scroll
        send_string("Zh");
        n = 0;
        while (!m_active && n < 50) begin
            @(negedge CLOCK);
            n++;
        end
        if (!m_active) timeout("z_wait");
        repeat (2) @(negedge CLOCK);
        do_reset(1);
        repeat (10) @(negedge CLOCK);

        // randomized traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            char_valid = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 3) == 0) char_in = 8'($urandom_range(0, 255));
            else char_in = pool[$urandom_range(0, pool.len() - 1)];
            RESET = ($urandom_range(0, 149) == 0);
            @(negedge CLOCK);
        end
        RESET      = 1'b0;
        char_valid = 1'b0;
        wait_idle();
        repeat (2) @(negedge CLOCK);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/hex_scroller.md
Name: hex_scroller

Overview:
- Downstream consumer of the character stream produced by the ROM-driven character reader.
- Buffers incoming 8-bit ASCII characters in a small FIFO and decodes each one to an active-low 7-segment pattern.
- Scrolls the characters right-to-left across HEX5..HEX0, one position per scroll tick. New characters enter at HEX0; older ones move toward HEX5.
- When the message runs out, it drains off the display with blanks, then idles.

Parameters:
- TICK_DIV, 25000000: clock cycles per scroll tick, minimum 2. Use 4 in simulation.
- FIFO_DEPTH, 8: character FIFO entries, power of 2, minimum 2.

Ports:
- CLOCK  in  1  system clock; all state updates on its rising edge.
- RESET  in  1  synchronous, active-high reset.
- char_in  in  8  ASCII character.
- char_valid  in  1  char_in is valid this cycle.
- char_ready  out  1  FIFO can accept; equals !full.
- HEX0..HEX5  out  7 each  active-low segments, bit order {g,f,e,d,c,b,a}, all registered.
- fifo_count  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- busy  out  1  1 when state != IDLE.

Behaviour:
- Clocking and reset:
  - Single clock domain. Reset is synchronous and active-high.
  - On RESET = 1 at a clock edge:
    - HEX0..HEX5 = 7'b1111111.
    - FIFO emptied; fifo_count = 0; char_ready = 1.
    - Tick counter = 0; state = IDLE; drain_cnt = 0; busy = 0.
  - RESET overrides any push or tick in the same cycle and aborts mid-scroll or mid-drain.
- Push handshake:
  - A push occurs when char_valid && char_ready.
  - char_ready depends only on FIFO occupancy: it is low when fifo_count == FIFO_DEPTH, even if a pop occurs in the same cycle.
  - Push and pop in the same cycle leave fifo_count unchanged.
- Tick generator:
  - Free-running counter from 0 to TICK_DIV-1, then wraps to 0.
  - tick = 1 for one cycle when counter == TICK_DIV-1. The first tick after reset occurs in cycle TICK_DIV-1.
- Pop and empty decisions on a tick use the FIFO state before any push in that cycle. A char pushed on a tick cycle is displayed at the next tick at the earliest.
- Shift operation on a tick:
  - HEX5<=HEX4, HEX4<=HEX3, HEX3<=HEX2, HEX2<=HEX1, HEX1<=HEX0.
  - HEX0 <= the decoded popped char, or 7'b1111111 for a blank.
- State machine (acts only on tick cycles; holds otherwise):
  - IDLE:
    - FIFO non-empty: pop and shift in char; go to SCROLL.
    - FIFO empty: no shift.
  - SCROLL:
    - FIFO non-empty: pop and shift char.
    - FIFO empty: shift blank; drain_cnt <= 1; go to DRAIN.
  - DRAIN:
    - FIFO non-empty: pop and shift char; drain_cnt <= 0; go to SCROLL.
    - FIFO empty: shift blank; drain_cnt++.
    - When drain_cnt reaches 6, the display is fully blank; go to IDLE with drain_cnt = 0.
- Decode (unlisted codes map to 7'b1111111, blank; space 8'd32 is also blank):
  - Letters: A(65)=0001000, b(98)=0000011, C(67)=1000110, d(100)=0100001, E(69)=0000110, F(70)=0001110, g(103)=0010000, h(104)=0001011.
  - Digits '0'-'9' (48-57): 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
- FIFO:
  - Circular buffer; read and write pointers wrap modulo FIFO_DEPTH.
  - Data and count are registered.
  - Pushes with no pop never overflow, because char_ready gates them.

Test Plan:
1. Reset check:
   - Stimulus: TICK_DIV=4; assert RESET for 2 cycles.
   - Response: all HEX = 7F; char_ready = 1; fifo_count = 0; busy = 0.
2. Single char, full scroll:
   - Stimulus: push 'A' (65) in cycle 0; run.
   - Response:
     - HEX0 = 0001000 after the tick at cycle 3; busy = 1.
     - Next tick: HEX1 = 0001000, HEX0 = 7F (state DRAIN).
     - After 6 blank ticks: all HEX = 7F, busy = 0.
3. FIFO full:
   - Stimulus: hold char_valid with "0123456789".
   - Response:
     - char_ready drops when fifo_count = 8.
     - Each tick frees one slot, and exactly one waiting char is accepted per slot.
     - No char is lost; HEX5..HEX0 read "012345" before the display starts draining.
4. Push on tick cycle:
   - Stimulus: FIFO empty, IDLE; push 'E' exactly in a tick cycle.
   - Response: no shift in that cycle; 'E' appears at HEX0 one tick later; fifo_count steps 1 then 0.
5. Resume from drain:
   - Stimulus: push "Cd"; after 2 blank shifts in DRAIN, push 'F'.
   - Response: on the next tick 'F' shifts in and the state returns to SCROLL. The display reads C, d, blank, blank, F, with F at HEX0.
6. Reset mid-operation and unknown code:
   - Stimulus: push 'Z' (90), then reset mid-scroll.
   - Response:
     - 'Z' shifts in as blank (7F) and busy rises.
     - RESET clears the FIFO and display in the next cycle, with no further shifts.
